credit_fifo_sender: RTL and testbench

- Transmit-side companion to the team's synchronous FIFO, which has no full indication and no backpressure.
- Accepts a val/rdy upstream stream and drives the FIFO write side (msg + val) one cycle later.
- Tracks free FIFO entries with a credit counter, so the FIFO is never overrun.
- The FIFO's read-side pop pulse (its ostream_rdy) returns to this block as credit_return.

---
 rtl/credit_fifo_sender_pkg.sv | 28 ++
 rtl/credit_fifo_sender_credit_counter.sv | 57 +++++
 rtl/credit_fifo_sender.sv | 69 ++++++
 tb/tb_credit_fifo_sender.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/credit_fifo_sender_pkg.sv
// Shared definitions for the credit-based FIFO sender and its downstream FIFO:
// credit/pointer width helper and reset values both sides must agree on.
package credit_fifo_sender_pkg;

    localparam int P_NUM_ENTRIES_DEFAULT = 8;
    localparam int P_BIT_WIDTH_DEFAULT   = 32;

    localparam logic RST_OSTREAM_VAL = 1'b0;
    localparam logic RST_CREDIT_ERR  = 1'b0;

    // Counter needs to represent 0..n inclusive.
    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

    // A freshly reset sender owns every FIFO entry.
    function automatic int credit_reset(input int n);
        return n;
    endfunction

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_DEC  = 2'd1,
        CNT_INC  = 2'd2,
        CNT_NET  = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/credit_fifo_sender_credit_counter.sv
// Saturating up/down credit counter; flags a return that arrives while already
// holding every credit.
module credit_counter
    import credit_fifo_sender_pkg::*;
#(
    parameter int p_max = P_NUM_ENTRIES_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            inc,
    input  logic                            dec,
    output logic [credit_width(p_max)-1:0]  count,
    output logic                            overflow
);

    localparam int W = credit_width(p_max);
    localparam logic [W-1:0] MAX_CNT = W'(credit_reset(p_max));
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] count_q, count_d;
    cnt_op_e      op;
    logic         at_max;

    assign at_max = (count_q == MAX_CNT);

    always_comb begin
        op = CNT_HOLD;
        unique case ({inc, dec})
            2'b01:   op = CNT_DEC;
            2'b10:   op = CNT_INC;
            2'b11:   op = CNT_NET;
            default: op = CNT_HOLD;
        endcase
    end

    // Caller gates dec with count != 0, so only the increment needs a clamp.
    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        unique case (op)
            CNT_DEC: count_d = count_q - ONE;
            CNT_INC: begin
                if (at_max) overflow = 1'b1;
                else        count_d  = count_q + ONE;
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= MAX_CNT;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/credit_fifo_sender.sv
// Write-side front end for a FIFO with no full flag: accepts val/rdy traffic,
// registers it onto the FIFO write port, and never issues more than it has credits for.
module credit_fifo_sender
    import credit_fifo_sender_pkg::*;
#(
    parameter int p_num_entries = P_NUM_ENTRIES_DEFAULT,
    parameter int p_bit_width   = P_BIT_WIDTH_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [p_bit_width-1:0]                  istream_msg,
    input  logic                                    istream_val,
    output logic                                    istream_rdy,
    output logic [p_bit_width-1:0]                  ostream_msg,
    output logic                                    ostream_val,
    input  logic                                    credit_return,
    output logic [credit_width(p_num_entries)-1:0]  credits,
    output logic                                    credit_err
);

    localparam int CW = credit_width(p_num_entries);

    logic [CW-1:0]          count;
    logic                   overflow;
    logic                   fire;
    logic [p_bit_width-1:0] msg_q, msg_d;
    logic                   val_q, val_d;
    logic                   err_q, err_d;

    // Ready comes from registered credit state only.
    assign istream_rdy = (count != '0);
    assign fire        = istream_val & istream_rdy;

    credit_counter #(
        .p_max    (p_num_entries)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (credit_return),
        .dec      (fire),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        msg_d = msg_q;
        val_d = fire;
        err_d = err_q | overflow;
        if (fire) msg_d = istream_msg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_q <= '0;
            val_q <= RST_OSTREAM_VAL;
            err_q <= RST_CREDIT_ERR;
        end else begin
            msg_q <= msg_d;
            val_q <= val_d;
            err_q <= err_d;
        end
    end

    assign ostream_msg = msg_q;
    assign ostream_val = val_q;
    assign credits     = count;
    assign credit_err  = err_q;

endmodule

// File: tb/tb_credit_fifo_sender.sv
// Directed bench for credit_fifo_sender with a 4-entry FIFO and 8-bit messages.
module tb_credit_fifo_sender;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] istream_msg;
    logic          istream_val;
    logic          istream_rdy;
    logic [BW-1:0] ostream_msg;
    logic          ostream_val;
    logic          credit_return;
    logic [CW-1:0] credits;
    logic          credit_err;

    int total = 0;
    int fails = 0;

    credit_fifo_sender #(
        .p_num_entries (N),
        .p_bit_width   (BW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .istream_msg   (istream_msg),
        .istream_val   (istream_val),
        .istream_rdy   (istream_rdy),
        .ostream_msg   (ostream_msg),
        .ostream_val   (ostream_val),
        .credit_return (credit_return),
        .credits       (credits),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int cr, input logic rdy,
                             input logic val, input logic err);
        chk({tag, ".credits"}, 32'(credits), 32'(cr));
        chk({tag, ".rdy"},     32'(istream_rdy), 32'(rdy));
        chk({tag, ".oval"},    32'(ostream_val), 32'(val));
        chk({tag, ".err"},     32'(credit_err), 32'(err));
    endtask

    initial begin
        reset = 1'b1; istream_msg = '0; istream_val = 1'b0; credit_return = 1'b0;
        repeat (2) @(negedge clk);
        chk_state("rst_held", N, 1'b1, 1'b0, 1'b0);
        chk("rst_held.msg", 32'(ostream_msg), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk_state("idle", N, 1'b1, 1'b0, 1'b0);

        // Burst of four fills every credit.
        for (int i = 0; i < 4; i++) begin
            istream_val = 1'b1; istream_msg = 8'hA0 + 8'(i);
            @(negedge clk);
            chk_state($sformatf("burst%0d", i), 3 - i, (i != 3), 1'b1, 1'b0);
            chk($sformatf("burst%0d.msg", i), 32'(ostream_msg), 32'hA0 + 32'(i));
        end

        // Fifth message stalls at zero credits.
        istream_msg = 8'hA4;
        @(negedge clk);
        chk_state("stall", 0, 1'b0, 1'b0, 1'b0);
        chk("stall.msg_hold", 32'(ostream_msg), 32'hA3);

        credit_return = 1'b1;
        @(negedge clk);
        credit_return = 1'b0;
        chk_state("ret_at_empty", 1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        istream_val = 1'b0;
        chk_state("a4_sent", 0, 1'b0, 1'b1, 1'b0);
        chk("a4_sent.msg", 32'(ostream_msg), 32'hA4);

        // Bring credits to 2, then fire and return together for 10 cycles.
        credit_return = 1'b1;
        repeat (2) @(negedge clk);
        chk_state("two_credits", 2, 1'b1, 1'b0, 1'b0);
        istream_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            istream_msg = 8'hB0 + 8'(i);
            @(negedge clk);
            chk_state($sformatf("net%0d", i), 2, 1'b1, 1'b1, 1'b0);
            chk($sformatf("net%0d.msg", i), 32'(ostream_msg), 32'hB0 + 32'(i));
        end
        istream_val = 1'b0;
        @(negedge clk);
        chk_state("net_done", 3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("full_again", 4, 1'b1, 1'b0, 1'b0);

        // Overflow return at full credits.
        @(negedge clk);
        credit_return = 1'b0;
        chk_state("overflow", 4, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk_state("err_sticky", 4, 1'b1, 1'b0, 1'b1);

        // Fire plus return at full credits is net zero, not an overflow change.
        istream_val = 1'b1; istream_msg = 8'hC0; credit_return = 1'b1;
        @(negedge clk);
        credit_return = 1'b0;
        chk_state("full_net", 4, 1'b1, 1'b1, 1'b1);
        chk("full_net.msg", 32'(ostream_msg), 32'hC0);

        // Three more accepts leave credits=1 with a message on the output.
        for (int i = 1; i < 4; i++) begin
            istream_msg = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        istream_val = 1'b0;
        chk_state("pre_rst", 1, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset away from any clock edge.
        #2 reset = 1'b1;
        #1 chk_state("async_rst", N, 1'b1, 1'b0, 1'b0);
        chk("async_rst.msg", 32'(ostream_msg), 32'h0);
        #1 reset = 1'b0;

        istream_val = 1'b1; istream_msg = 8'h5A;
        @(negedge clk);
        istream_val = 1'b0;
        chk_state("post_rst", N - 1, 1'b1, 1'b1, 1'b0);
        chk("post_rst.msg", 32'(ostream_msg), 32'h5A);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
